// File: rtl/nco_sched_pkg.sv
// Shared types and default widths for the NCO hop scheduler.
// NCO_SCHED_GUARD_EN enables the muted GUARD interval between hops.
package nco_sched_pkg;

  localparam int DEF_PHASE_W = 32;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_AW      = 4;
  localparam int DEF_DWELL_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } state_t;

  // Logical layout of one hop-table entry at the default widths.
  typedef struct packed {
    logic [DEF_PHASE_W-1:0] inc_a;
    logic [DEF_PHASE_W-1:0] inc_b;
    logic [DEF_DWELL_W-1:0] dwell;
  } hop_entry_t;

endpackage

// File: rtl/nco_hop_table.sv
// Hop table: register array with asynchronous read; writes are dropped
// (and flagged on wr_rej one cycle later) while the scheduler is busy.
module nco_hop_table
  import nco_sched_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = DEF_AW,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               busy,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PHASE_W-1:0] wr_inc_a,
  input  logic [PHASE_W-1:0] wr_inc_b,
  input  logic [DWELL_W-1:0] wr_dwell,
  output logic               wr_rej,
  input  logic [AW-1:0]      rd_addr,
  output logic [PHASE_W-1:0] rd_inc_a,
  output logic [PHASE_W-1:0] rd_inc_b,
  output logic [DWELL_W-1:0] rd_dwell
);

  logic [PHASE_W-1:0] inc_a_mem [DEPTH];
  logic [PHASE_W-1:0] inc_b_mem [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];

  // Contents intentionally survive rst so a table can be reloaded once.
  always_ff @(posedge clk) begin
    if (we && !busy) begin
      inc_a_mem[wr_addr] <= wr_inc_a;
      inc_b_mem[wr_addr] <= wr_inc_b;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_rej <= 1'b0;
    else     wr_rej <= we & busy;
  end

  assign rd_inc_a = inc_a_mem[rd_addr];
  assign rd_inc_b = inc_b_mem[rd_addr];
  assign rd_dwell = dwell_mem[rd_addr];

endmodule

// File: rtl/nco_hop_scheduler.sv
// Steps NCO A/B phase increments through the hop table with per-entry dwell.
// Optional NCO_SCHED_GUARD_EN inserts GUARD_CYC muted cycles before each later hop.
module nco_hop_scheduler
  import nco_sched_pkg::*;
#(
  parameter int PHASE_W   = DEF_PHASE_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = DEF_AW,
  parameter int DWELL_W   = DEF_DWELL_W,
  parameter int GUARD_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_we,
  input  logic [AW-1:0]      tbl_addr,
  input  logic [PHASE_W-1:0] tbl_inc_a,
  input  logic [PHASE_W-1:0] tbl_inc_b,
  input  logic [DWELL_W-1:0] tbl_dwell,
  output logic               wr_rej,
  input  logic [AW-1:0]      last_idx,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic               hop_stb,
  output logic [AW-1:0]      cur_idx,
  output logic [PHASE_W-1:0] phi_inc_a,
  output logic [PHASE_W-1:0] phi_inc_b,
  output logic               dac_en
);

  if (GUARD_CYC < 1 || (1 << AW) != DEPTH) begin : g_param_chk
    $error("nco_hop_scheduler: need GUARD_CYC >= 1 and DEPTH == 2**AW");
  end

  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [AW-1:0]      last_q, last_n, idx_n, rd_idx, nxt_idx;
  logic [PHASE_W-1:0] a_n, b_n, rd_a, rd_b;
  logic [DWELL_W-1:0] rd_dwell;
  logic               busy_n, done_n, stb_n, dac_n, do_hop, do_idle;

  nco_hop_table #(
    .PHASE_W(PHASE_W), .DEPTH(DEPTH), .AW(AW), .DWELL_W(DWELL_W)
  ) u_tbl (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .we       (tbl_we),
    .wr_addr  (tbl_addr),
    .wr_inc_a (tbl_inc_a),
    .wr_inc_b (tbl_inc_b),
    .wr_dwell (tbl_dwell),
    .wr_rej   (wr_rej),
    .rd_addr  (rd_idx),
    .rd_inc_a (rd_a),
    .rd_inc_b (rd_b),
    .rd_dwell (rd_dwell)
  );

  always_comb begin
    nxt_idx = (cur_idx == last_q) ? '0 : cur_idx + AW'(1);
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_q;
    idx_n   = cur_idx;
    a_n     = phi_inc_a;
    b_n     = phi_inc_b;
    busy_n  = busy;
    dac_n   = dac_en;
    stb_n   = 1'b0;
    done_n  = 1'b0;
    rd_idx  = nxt_idx;
    do_hop  = 1'b0;
    do_idle = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          rd_idx = '0;
          last_n = last_idx;
          do_hop = 1'b1;
        end
      end
      RUN: begin
        if (stop) do_idle = 1'b1;
        else if (cnt == '0) begin
          if (cur_idx == last_q && !loop_en) begin
            do_idle = 1'b1;
            done_n  = 1'b1;
          end
`ifdef NCO_SCHED_GUARD_EN
          else begin
            state_n = GUARD;
            cnt_n   = DWELL_W'(GUARD_CYC - 1);
            a_n     = '0;
            b_n     = '0;
            dac_n   = 1'b0;
          end
`else
          else do_hop = 1'b1;
`endif
        end
        else cnt_n = cnt - DWELL_W'(1);
      end
`ifdef NCO_SCHED_GUARD_EN
      GUARD: begin
        if (stop)            do_idle = 1'b1;
        else if (cnt == '0)  do_hop  = 1'b1;
        else                 cnt_n   = cnt - DWELL_W'(1);
      end
`endif
      default: do_idle = 1'b1;
    endcase
    // A hop loads dwell-1 so the hop_stb cycle counts toward the dwell.
    if (do_hop) begin
      state_n = RUN;
      idx_n   = rd_idx;
      a_n     = rd_a;
      b_n     = rd_b;
      cnt_n   = (rd_dwell == '0) ? '0 : rd_dwell - DWELL_W'(1);
      stb_n   = 1'b1;
      busy_n  = 1'b1;
      dac_n   = 1'b1;
    end
    if (do_idle) begin
      state_n = IDLE;
      idx_n   = '0;
      a_n     = '0;
      b_n     = '0;
      busy_n  = 1'b0;
      dac_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_q    <= '0;
      cur_idx   <= '0;
      phi_inc_a <= '0;
      phi_inc_b <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hop_stb   <= 1'b0;
      dac_en    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last_q    <= last_n;
      cur_idx   <= idx_n;
      phi_inc_a <= a_n;
      phi_inc_b <= b_n;
      busy      <= busy_n;
      done      <= done_n;
      hop_stb   <= stb_n;
      dac_en    <= dac_n;
    end
  end

endmodule

// File: tb/tb_nco_hop_scheduler.sv
// Scoreboard bench for nco_hop_scheduler: per-cycle expected outputs are queued
// with their absolute cycle number and compared at the falling edge.
module tb_nco_hop_scheduler;

  localparam logic [31:0] E0A = 32'h0CCC_CCCD, E0B = 32'h4000_0000;
  localparam logic [31:0] E1A = 32'h1999_999A, E1B = 32'h2000_0000;
  localparam logic [31:0] XA  = 32'h1111_1111, XB  = 32'h2222_2222;
`ifdef NCO_SCHED_GUARD_EN
  localparam int E1_AT = 10;
`else
  localparam int E1_AT = 6;
`endif

  logic        clk = 1'b0, rst, tbl_we, loop_en, start, stop;
  logic [3:0]  tbl_addr, last_idx, cur_idx;
  logic [31:0] tbl_inc_a, tbl_inc_b, phi_inc_a, phi_inc_b;
  logic [23:0] tbl_dwell;
  logic        wr_rej, busy, done, hop_stb, dac_en;

  nco_hop_scheduler #(.GUARD_CYC(4)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_inc_a(tbl_inc_a), .tbl_inc_b(tbl_inc_b), .tbl_dwell(tbl_dwell),
    .wr_rej(wr_rej), .last_idx(last_idx), .loop_en(loop_en), .start(start),
    .stop(stop), .busy(busy), .done(done), .hop_stb(hop_stb), .cur_idx(cur_idx),
    .phi_inc_a(phi_inc_a), .phi_inc_b(phi_inc_b), .dac_en(dac_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [127:0] v;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, c0 = 0, rej_t = -1;
  int   n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // {busy, done, hop_stb, dac_en, wr_rej, cur_idx, phi_inc_a, phi_inc_b}
  function automatic logic [127:0] pk(input logic b, d, s, e, r, input logic [3:0] i,
                                      input logic [31:0] a, input logic [31:0] bb);
    return {55'd0, b, d, s, e, r, i, a, bb};
  endfunction

  function automatic logic [127:0] vec(input logic b, d, s, e, input logic [3:0] i,
                                       input logic [31:0] a, input logic [31:0] bb);
    return pk(b, d, s, e, 1'b0, i, a, bb);
  endfunction

  task automatic exp_seg(input string tg, input int t0, input int t1, input logic [127:0] v);
    for (int t = t0; t <= t1; t++) begin
      exp_t e;
      e.cyc = c0 + t;
      e.v   = v | ((t == rej_t) ? (128'd1 << 68) : 128'd0);
      e.tag = $sformatf("%s_c%0d", tg, t);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) chk({e.tag, "_stale"}, 128'(e.cyc), 128'(cyc));
      else chk(e.tag, pk(busy, done, hop_stb, dac_en, wr_rej, cur_idx, phi_inc_a, phi_inc_b), e.v);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < c0 + t) step();
  endtask

  task automatic wr(input logic [3:0] ad, input logic [31:0] a, input logic [31:0] b,
                    input logic [23:0] d);
    tbl_we = 1'b1; tbl_addr = ad; tbl_inc_a = a; tbl_inc_b = b; tbl_dwell = d;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic go();
    step();
    start = 1'b1;
    c0 = cyc;
  endtask

  // Expected timeline for the two-entry table, loop_en=0.
  task automatic exp_t1(input string tg);
    logic [127:0] idle_v;
    idle_v = vec(0, 0, 0, 0, 4'd0, 0, 0);
    exp_seg(tg, 0, 0, idle_v);
    exp_seg(tg, 1, 1, vec(1, 0, 1, 1, 4'd0, E0A, E0B));
    exp_seg(tg, 2, 5, vec(1, 0, 0, 1, 4'd0, E0A, E0B));
`ifdef NCO_SCHED_GUARD_EN
    exp_seg(tg, 6, 9, vec(1, 0, 0, 0, 4'd0, 0, 0));
`endif
    exp_seg(tg, E1_AT, E1_AT, vec(1, 0, 1, 1, 4'd1, E1A, E1B));
    exp_seg(tg, E1_AT + 1, E1_AT + 2, vec(1, 0, 0, 1, 4'd1, E1A, E1B));
    exp_seg(tg, E1_AT + 3, E1_AT + 3, vec(0, 1, 0, 0, 4'd0, 0, 0));
    exp_seg(tg, E1_AT + 4, E1_AT + 4, idle_v);
  endtask

  initial begin
    logic [127:0] idle_v;
    idle_v = vec(0, 0, 0, 0, 4'd0, 0, 0);
    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_inc_a = '0; tbl_inc_b = '0;
    tbl_dwell = '0; last_idx = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    c0 = cyc;
    exp_seg("reset", 0, 2, idle_v);
    wait_to(3);

    wr(4'd0, E0A, E0B, 24'd5);
    wr(4'd1, E1A, E1B, 24'd3);

    // Single pass through two entries.
    last_idx = 4'd1; loop_en = 1'b0;
    go();
    exp_t1("once");
    step(); start = 1'b0;
    wait_to(E1_AT + 4);

    // Looping, aborted by stop at cycle 11.
    loop_en = 1'b1;
    go();
    exp_seg("loop", 0, 0, idle_v);
    exp_seg("loop", 1, 1, vec(1, 0, 1, 1, 4'd0, E0A, E0B));
    exp_seg("loop", 2, 5, vec(1, 0, 0, 1, 4'd0, E0A, E0B));
`ifdef NCO_SCHED_GUARD_EN
    exp_seg("loop", 6, 9, vec(1, 0, 0, 0, 4'd0, 0, 0));
    exp_seg("loop", 10, 10, vec(1, 0, 1, 1, 4'd1, E1A, E1B));
    exp_seg("loop", 11, 11, vec(1, 0, 0, 1, 4'd1, E1A, E1B));
`else
    exp_seg("loop", 6, 6, vec(1, 0, 1, 1, 4'd1, E1A, E1B));
    exp_seg("loop", 7, 8, vec(1, 0, 0, 1, 4'd1, E1A, E1B));
    exp_seg("loop", 9, 9, vec(1, 0, 1, 1, 4'd0, E0A, E0B));
    exp_seg("loop", 10, 11, vec(1, 0, 0, 1, 4'd0, E0A, E0B));
`endif
    exp_seg("loop", 12, 13, idle_v);
    step(); start = 1'b0;
    wait_to(11);
    stop = 1'b1;
    step(); stop = 1'b0;
    wait_to(13);

    // Zero dwell behaves as one cycle.
    wr(4'd0, XA, XB, 24'd0);
    last_idx = 4'd0; loop_en = 1'b0;
    go();
    exp_seg("dw0", 0, 0, idle_v);
    exp_seg("dw0", 1, 1, vec(1, 0, 1, 1, 4'd0, XA, XB));
    exp_seg("dw0", 2, 2, vec(0, 1, 0, 0, 4'd0, 0, 0));
    exp_seg("dw0", 3, 3, idle_v);
    step(); start = 1'b0;
    wait_to(3);
    wr(4'd0, E0A, E0B, 24'd5);

    // Write and restart while busy; last_idx change also ignored.
    last_idx = 4'd1;
    rej_t = 3;
    go();
    exp_t1("busywr");
    step(); start = 1'b0;
    wait_to(2);
    wr(4'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 24'd1);
    start = 1'b1; last_idx = 4'd0;
    step(); start = 1'b0;
    wait_to(E1_AT + 4);
    rej_t = -1;
    last_idx = 4'd1;

    // Synchronous reset while entry 1 is active.
    go();
    exp_seg("rstmid", 0, 0, idle_v);
    exp_seg("rstmid", 1, 1, vec(1, 0, 1, 1, 4'd0, E0A, E0B));
    exp_seg("rstmid", 2, 5, vec(1, 0, 0, 1, 4'd0, E0A, E0B));
`ifdef NCO_SCHED_GUARD_EN
    exp_seg("rstmid", 6, 9, vec(1, 0, 0, 0, 4'd0, 0, 0));
`endif
    exp_seg("rstmid", E1_AT, E1_AT, vec(1, 0, 1, 1, 4'd1, E1A, E1B));
    exp_seg("rstmid", E1_AT + 1, E1_AT + 1, vec(1, 0, 0, 1, 4'd1, E1A, E1B));
    exp_seg("rstmid", E1_AT + 2, E1_AT + 3, idle_v);
    step(); start = 1'b0;
    wait_to(E1_AT + 1);
    rst = 1'b1;
    step(); rst = 1'b0;
    wait_to(E1_AT + 3);

    // Fresh start after reset begins at entry 0.
    go();
    exp_seg("fresh", 0, 0, idle_v);
    exp_seg("fresh", 1, 1, vec(1, 0, 1, 1, 4'd0, E0A, E0B));
    exp_seg("fresh", 2, 2, vec(1, 0, 0, 1, 4'd0, E0A, E0B));
    exp_seg("fresh", 3, 4, idle_v);
    step(); start = 1'b0;
    wait_to(2);
    stop = 1'b1;
    step(); stop = 1'b0;
    wait_to(4);

    // start and stop together in IDLE do nothing.
    go();
    stop = 1'b1;
    exp_seg("ststp", 0, 3, idle_v);
    step(); start = 1'b0; stop = 1'b0;
    wait_to(3);

    repeat (3) step();
    chk("sb_drain", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
